ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 74 +++++++
 rtl/ex_stage_div_iter.sv | 97 +++++++++
 rtl/ex_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared widths, bus payload layouts, decode constants and divider states for the EX stage.
package ex_stage_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned ID_TO_EX_WD  = 159;
   localparam int unsigned EX_TO_MEM_WD = 76;
   localparam int unsigned EX_TO_RF_WD  = 38;
   localparam int unsigned STALL_WD     = 6;
   localparam int unsigned STALL_ID     = 2;
   localparam int unsigned STALL_EX     = 3;
   localparam int unsigned CNT_WD       = 5;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // alu_op bit positions, one-hot
   localparam int unsigned ALU_ADD  = 11;
   localparam int unsigned ALU_SUB  = 10;
   localparam int unsigned ALU_SLT  = 9;
   localparam int unsigned ALU_SLTU = 8;
   localparam int unsigned ALU_AND  = 7;
   localparam int unsigned ALU_NOR  = 6;
   localparam int unsigned ALU_OR   = 5;
   localparam int unsigned ALU_XOR  = 4;
   localparam int unsigned ALU_SLL  = 3;
   localparam int unsigned ALU_SRL  = 2;
   localparam int unsigned ALU_SRA  = 1;
   localparam int unsigned ALU_LUI  = 0;

   localparam logic [5:0] FN_MFHI = 6'h10;
   localparam logic [5:0] FN_MTHI = 6'h11;
   localparam logic [5:0] FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MTLO = 6'h13;
   localparam logic [5:0] FN_DIV  = 6'h1A;
   localparam logic [5:0] FN_DIVU = 6'h1B;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic [11:0]     alu_op;
      logic [2:0]      sel_src1;
      logic [3:0]      sel_src2;
      logic            ram_en;
      logic [3:0]      ram_wen;
      logic            rf_we;
      logic [4:0]      rf_waddr;
      logic            sel_rf_res;
      logic [XLEN-1:0] rs_data;
      logic [XLEN-1:0] rt_data;
   } id_to_ex_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            ram_en;
      logic [3:0]      ram_wen;
      logic            sel_rf_res;
      logic            rf_we;
      logic [4:0]      rf_waddr;
      logic [XLEN-1:0] ex_result;
   } ex_to_mem_t;

   typedef struct packed {
      logic            rf_we;
      logic [4:0]      rf_waddr;
      logic [XLEN-1:0] ex_result;
   } ex_to_rf_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, sign fix-up applied on the outputs.
module div_iter
   import ex_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            signed_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   div_state_e        r_state;
   div_state_e        w_next;
   logic [CNT_WD-1:0] r_cnt;
   logic [XLEN-1:0]   r_quot;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_dvs;
   logic [XLEN-1:0]   r_dvd;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_dvs_zero;

   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic [XLEN:0]     w_shift;
   logic [XLEN:0]     w_diff;
   logic              w_ge;

   assign w_a_mag = (signed_op && a[XLEN-1]) ? (~a + XLEN'(1)) : a;
   assign w_b_mag = (signed_op && b[XLEN-1]) ? (~b + XLEN'(1)) : b;

   // Partial remainder is always below the divisor, so bit XLEN of the difference is the borrow.
   assign w_shift = {r_rem, r_quot[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, r_dvs};
   assign w_ge    = ~w_diff[XLEN];

   always_ff @(posedge clk) begin
      if (rst) r_state <= DIV_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         DIV_IDLE: if (start) w_next = DIV_RUN;
         DIV_RUN: begin
            busy = 1'b1;
            if (r_cnt == CNT_WD'(XLEN - 1)) w_next = DIV_DONE;
         end
         DIV_DONE: begin
            done   = 1'b1;
            w_next = DIV_IDLE;
         end
         default: w_next = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_dvs      <= '0;
         r_dvd      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dvs_zero <= 1'b0;
      end else if (r_state == DIV_IDLE && start) begin
         r_cnt      <= '0;
         r_quot     <= w_a_mag;
         r_rem      <= '0;
         r_dvs      <= w_b_mag;
         r_dvd      <= a;
         r_neg_q    <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
         r_neg_r    <= signed_op & a[XLEN-1];
         r_dvs_zero <= (b == '0);
      end else if (r_state == DIV_RUN) begin
         r_cnt  <= r_cnt + CNT_WD'(1);
         r_quot <= {r_quot[XLEN-2:0], w_ge};
         r_rem  <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      end
   end

   // Zero divisor bypasses sign correction entirely.
   assign quotient  = r_dvs_zero ? '1 :
                      (r_neg_q ? (~r_quot + XLEN'(1)) : r_quot);
   assign remainder = r_dvs_zero ? r_dvd :
                      (r_neg_r ? (~r_rem + XLEN'(1)) : r_rem);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: input pipeline register, ALU, HI/LO registers, divider control and data SRAM request.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
   output logic                    ex_is_load,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_wen,
   output logic [XLEN-1:0]         data_sram_addr,
   output logic [XLEN-1:0]         data_sram_wdata,
   output logic                    stallreq_for_ex
);

   id_to_ex_t       r_id;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic            r_div_fin;

   logic            w_ex_adv;
   logic            w_rtype;
   logic            w_is_mfhi, w_is_mthi, w_is_mflo, w_is_mtlo, w_is_div, w_is_divu;
   logic [XLEN-1:0] w_src1, w_src2, w_alu_res, w_result;
   logic            w_div_start, w_div_busy, w_div_done;
   logic [XLEN-1:0] w_div_q, w_div_r;
   ex_to_mem_t      w_mem;
   ex_to_rf_t       w_rf;

   assign w_ex_adv = (stall[STALL_EX] == NO_STOP);

   // Input register: ID stalled while EX drains inserts a bubble.
   always_ff @(posedge clk) begin
      if (rst)
         r_id <= '0;
      else if (stall[STALL_ID] == STOP && stall[STALL_EX] == NO_STOP)
         r_id <= '0;
      else if (stall[STALL_ID] == NO_STOP)
         r_id <= id_to_ex_t'(id_to_ex_bus);
   end

   assign w_rtype   = (r_id.inst[31:26] == 6'd0);
   assign w_is_mfhi = w_rtype && (r_id.inst[5:0] == FN_MFHI);
   assign w_is_mthi = w_rtype && (r_id.inst[5:0] == FN_MTHI);
   assign w_is_mflo = w_rtype && (r_id.inst[5:0] == FN_MFLO);
   assign w_is_mtlo = w_rtype && (r_id.inst[5:0] == FN_MTLO);
   assign w_is_div  = w_rtype && (r_id.inst[5:0] == FN_DIV);
   assign w_is_divu = w_rtype && (r_id.inst[5:0] == FN_DIVU);

   always_comb begin
      w_src1 = '0;
      if      (r_id.sel_src1[0]) w_src1 = r_id.rs_data;
      else if (r_id.sel_src1[1]) w_src1 = r_id.pc;
      else if (r_id.sel_src1[2]) w_src1 = XLEN'(r_id.inst[10:6]);
   end

   always_comb begin
      w_src2 = '0;
      if      (r_id.sel_src2[0]) w_src2 = r_id.rt_data;
      else if (r_id.sel_src2[1]) w_src2 = {{16{r_id.inst[15]}}, r_id.inst[15:0]};
      else if (r_id.sel_src2[2]) w_src2 = XLEN'(8);
      else if (r_id.sel_src2[3]) w_src2 = XLEN'(r_id.inst[15:0]);
   end

   always_comb begin
      w_alu_res = '0;
      if (r_id.alu_op[ALU_ADD])  w_alu_res |= w_src1 + w_src2;
      if (r_id.alu_op[ALU_SUB])  w_alu_res |= w_src1 - w_src2;
      if (r_id.alu_op[ALU_SLT])  w_alu_res |= XLEN'($signed(w_src1) < $signed(w_src2));
      if (r_id.alu_op[ALU_SLTU]) w_alu_res |= XLEN'(w_src1 < w_src2);
      if (r_id.alu_op[ALU_AND])  w_alu_res |= w_src1 & w_src2;
      if (r_id.alu_op[ALU_NOR])  w_alu_res |= ~(w_src1 | w_src2);
      if (r_id.alu_op[ALU_OR])   w_alu_res |= w_src1 | w_src2;
      if (r_id.alu_op[ALU_XOR])  w_alu_res |= w_src1 ^ w_src2;
      if (r_id.alu_op[ALU_SLL])  w_alu_res |= w_src2 << w_src1[4:0];
      if (r_id.alu_op[ALU_SRL])  w_alu_res |= w_src2 >> w_src1[4:0];
      if (r_id.alu_op[ALU_SRA])  w_alu_res |= XLEN'($signed(w_src2) >>> w_src1[4:0]);
      if (r_id.alu_op[ALU_LUI])  w_alu_res |= {w_src2[15:0], 16'h0000};
   end

   assign w_result = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : w_alu_res);

   // Blocks a restart while a finished divide is still held in EX by a downstream stall.
   always_ff @(posedge clk) begin
      if (rst || w_ex_adv) r_div_fin <= 1'b0;
      else if (w_div_done) r_div_fin <= 1'b1;
   end

   assign w_div_start     = (w_is_div | w_is_divu) & ~r_div_fin;
   assign stallreq_for_ex = (w_div_start & ~w_div_done) | w_div_busy;

   div_iter u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (w_div_start),
      .signed_op (w_is_div),
      .a         (r_id.rs_data),
      .b         (r_id.rt_data),
      .busy      (w_div_busy),
      .done      (w_div_done),
      .quotient  (w_div_q),
      .remainder (w_div_r)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_div_done) begin
         r_hi <= w_div_r;
         r_lo <= w_div_q;
      end else if (w_ex_adv) begin
         if (w_is_mthi) r_hi <= r_id.rs_data;
         if (w_is_mtlo) r_lo <= r_id.rs_data;
      end
   end

   assign w_mem = '{pc: r_id.pc, ram_en: r_id.ram_en, ram_wen: r_id.ram_wen,
                    sel_rf_res: r_id.sel_rf_res, rf_we: r_id.rf_we,
                    rf_waddr: r_id.rf_waddr, ex_result: w_result};
   assign w_rf  = '{rf_we: r_id.rf_we, rf_waddr: r_id.rf_waddr, ex_result: w_result};

   assign ex_to_mem_bus   = w_mem;
   assign ex_to_rf_bus    = w_rf;
   assign ex_is_load      = r_id.ram_en & r_id.sel_rf_res;
   assign data_sram_en    = r_id.ram_en & ~stallreq_for_ex;
   assign data_sram_wen   = data_sram_en ? r_id.ram_wen : 4'h0;
   assign data_sram_addr  = w_alu_res;
   assign data_sram_wdata = r_id.rt_data;

endmodule
